fios_operand_server: RTL and testbench

Operand server and result collector sitting on the host side of the FIOS Montgomery multiplier. It stores operands A, B and P (s 17-bit words each), issues the start pulse, and answers the multiplier's `a_shift_o`/`b_fetch_o`/`p_fetch_o` requests. It captures the `RES_push_o`/`RES_o` word stream and returns the s-word result to the host over a valid/ready stream.

---
 rtl/fios_operand_server.sv | 154 +++++++++++++++
 tb/tb_fios_operand_server.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fios_operand_server.sv
// Host-side operand store and result collector for the FIOS Montgomery multiplier.
// Serves A windows and B/P words on request and streams the captured result back.
module fios_operand_server #(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  ld_valid_i,
    input  logic [1:0]            ld_sel_i,
    input  logic [16:0]           ld_data_i,
    output logic                  ld_ready_o,
    input  logic                  go_i,
    output logic                  busy_o,
    output logic                  res_valid_o,
    output logic [16:0]           res_data_o,
    input  logic                  res_ready_i,
    output logic                  err_o,
    output logic                  start_o,
    output logic [PE_NB*17-1:0]   a_o,
    output logic [16:0]           b_o,
    output logic [16:0]           p_o,
    input  logic                  a_shift_i,
    input  logic                  b_fetch_i,
    input  logic                  p_fetch_i,
    input  logic                  res_push_i,
    input  logic [16:0]           res_i,
    input  logic                  done_i
);
    localparam int NW = (s + PE_NB - 1) / PE_NB;
    localparam int IW = (s > 1) ? $clog2(s) : 1;
    localparam int AW = $clog2(NW + 1);
    localparam int RW = $clog2(s + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [16:0]   a_mem [s];
    logic [16:0]   b_mem [s];
    logic [16:0]   p_mem [s];
    logic [16:0]   r_mem [s];
    logic [IW-1:0] la, lb, lp, b_idx, p_idx, o_idx;
    logic [AW-1:0] a_idx;
    logic [RW-1:0] r_idx;
    logic [31:0]   win_idx;
    logic          run, ld_fire, res_fire, last, r_full;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == IW'(s - 1)) ? '0 : x + 1'b1;
    endfunction

    assign run         = state == RUN;
    assign ld_ready_o  = state == IDLE;
    assign ld_fire     = ld_valid_i & ld_ready_o;
    assign busy_o      = state != IDLE;
    assign start_o     = state == START;
    assign res_valid_o = state == DRAIN;
    assign res_fire    = res_valid_o & res_ready_i;
    assign last        = o_idx == IW'(s - 1);
    assign r_full      = r_idx == RW'(s);
    assign res_data_o  = res_valid_o ? r_mem[o_idx] : '0;
    assign b_o         = b_mem[b_idx];
    assign p_o         = p_mem[p_idx];

    // Window slots past the end of A read as zero.
    always_comb begin
        a_o     = '0;
        win_idx = '0;
        for (int j = 0; j < PE_NB; j++) begin
            win_idx = 32'(a_idx) * 32'(PE_NB) + 32'(j);
            if (win_idx < 32'(s))
                a_o[17*j +: 17] = a_mem[win_idx[IW-1:0]];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (go_i) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (done_i) state_nxt = DRAIN;
            DRAIN:   if (res_fire && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            la    <= '0;
            lb    <= '0;
            lp    <= '0;
            a_idx <= '0;
            b_idx <= '0;
            p_idx <= '0;
            r_idx <= '0;
            o_idx <= '0;
            err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_fire) begin
                unique case (ld_sel_i)
                    2'd0:    la <= wrap_inc(la);
                    2'd1:    lb <= wrap_inc(lb);
                    2'd2:    lp <= wrap_inc(lp);
                    default: ;
                endcase
            end
            if (state == DRAIN && state_nxt == IDLE) begin
                la    <= '0;
                lb    <= '0;
                lp    <= '0;
                o_idx <= '0;
            end else if (res_fire) begin
                o_idx <= o_idx + 1'b1;
            end
            if (state == IDLE && go_i)
                err_o <= 1'b0;
            if (state == START) begin
                a_idx <= '0;
                b_idx <= '0;
                p_idx <= '0;
                r_idx <= '0;
                err_o <= 1'b0;
            end
            if (run) begin
                if (a_shift_i && a_idx != AW'(NW))
                    a_idx <= a_idx + 1'b1;
                if (b_fetch_i)
                    b_idx <= wrap_inc(b_idx);
                if (p_fetch_i)
                    p_idx <= wrap_inc(p_idx);
                if (res_push_i) begin
                    if (r_full) err_o <= 1'b1;
                    else        r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clock_i) begin
        if (ld_fire) begin
            unique case (ld_sel_i)
                2'd0:    a_mem[la] <= ld_data_i;
                2'd1:    b_mem[lb] <= ld_data_i;
                2'd2:    p_mem[lp] <= ld_data_i;
                default: ;
            endcase
        end
        if (run && res_push_i && !r_full)
            r_mem[r_idx[IW-1:0]] <= res_i;
    end
endmodule

// File: tb/tb_fios_operand_server.sv
// Randomized self-checking bench for fios_operand_server.
// A transaction-level model tracks arrays, indices and the error flag.
module tb_fios_operand_server;
    localparam int S  = 4;
    localparam int PE = 2;
    localparam int NW = (S + PE - 1) / PE;

    logic              clock_i = 0;
    logic              reset_i;
    logic              ld_valid_i, go_i, res_ready_i;
    logic [1:0]        ld_sel_i;
    logic [16:0]       ld_data_i, res_i;
    logic              ld_ready_o, busy_o, res_valid_o, err_o, start_o;
    logic [16:0]       res_data_o, b_o, p_o;
    logic [PE*17-1:0]  a_o;
    logic              a_shift_i, b_fetch_i, p_fetch_i, res_push_i, done_i;

    fios_operand_server #(.s(S), .PE_NB(PE)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .ld_valid_i(ld_valid_i), .ld_sel_i(ld_sel_i), .ld_data_i(ld_data_i),
        .ld_ready_o(ld_ready_o), .go_i(go_i), .busy_o(busy_o),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_ready_i(res_ready_i), .err_o(err_o), .start_o(start_o),
        .a_o(a_o), .b_o(b_o), .p_o(p_o),
        .a_shift_i(a_shift_i), .b_fetch_i(b_fetch_i), .p_fetch_i(p_fetch_i),
        .res_push_i(res_push_i), .res_i(res_i), .done_i(done_i)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int failures = 0;

    logic [16:0] ma [S];
    logic [16:0] mb [S];
    logic [16:0] mp [S];
    logic [16:0] mr [S];
    int li [3];
    int ai, bi, pi, ri;
    bit merr, in_run, draining;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PE*17-1:0] win(input int a);
        logic [PE*17-1:0] w;
        w = '0;
        for (int j = 0; j < PE; j++)
            if (a * PE + j < S) w[17*j +: 17] = ma[a*PE+j];
        return w;
    endfunction

    function automatic void mload(input logic [1:0] sel, input logic [16:0] d);
        if (sel == 2'd3) return;
        case (sel)
            2'd0: ma[li[0]] = d;
            2'd1: mb[li[1]] = d;
            default: mp[li[2]] = d;
        endcase
        li[sel] = (li[sel] + 1) % S;
    endfunction

    function automatic void mreset();
        for (int i = 0; i < 3; i++) li[i] = 0;
        ai = 0; bi = 0; pi = 0; ri = 0;
        merr = 0; in_run = 0; draining = 0;
    endfunction

    task automatic load(input logic [1:0] sel, input logic [16:0] d);
        ld_valid_i = 1; ld_sel_i = sel; ld_data_i = d;
        @(posedge clock_i); #1;
        ld_valid_i = 0;
        mload(sel, d);
    endtask

    task automatic go(input bit ld, input logic [1:0] sel, input logic [16:0] d);
        go_i = 1; ld_valid_i = ld; ld_sel_i = sel; ld_data_i = d;
        @(posedge clock_i); #1;
        go_i = 0; ld_valid_i = 0;
        if (ld) mload(sel, d);
        merr = 0;
        check("start_hi", start_o, 1);
        check("busy_start", busy_o, 1);
        check("err_clr", err_o, 0);
        check("ld_rdy_busy", ld_ready_o, 0);
        @(posedge clock_i); #1;
        ai = 0; bi = 0; pi = 0; ri = 0; in_run = 1;
        check("start_lo", start_o, 0);
        check("win_run0", a_o, win(0));
        check("b_run0", b_o, mb[0]);
    endtask

    task automatic step(input bit sh, input bit bf, input bit pf, input bit ps,
                        input logic [16:0] pd, input bit dn);
        a_shift_i = sh; b_fetch_i = bf; p_fetch_i = pf;
        res_push_i = ps; res_i = pd; done_i = dn;
        @(posedge clock_i); #1;
        a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0; res_push_i = 0; done_i = 0;
        if (in_run) begin
            if (sh && ai < NW) ai++;
            if (bf) bi = (bi + 1) % S;
            if (pf) pi = (pi + 1) % S;
            if (ps) begin
                if (ri < S) begin mr[ri] = pd; ri++; end
                else merr = 1;
            end
            if (dn) begin in_run = 0; draining = 1; end
        end
        check("a_win", a_o, win(ai));
        check("b_word", b_o, mb[bi]);
        check("p_word", p_o, mp[pi]);
        check("err", err_o, merr);
        check("busy", busy_o, in_run | draining);
        check("res_valid", res_valid_o, draining);
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        int cyc = 0;
        while (k < S && cyc < 200) begin
            check("drain_valid", res_valid_o, 1);
            check("drain_data", res_data_o, mr[k]);
            check("drain_err", err_o, merr);
            res_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clock_i); #1;
            if (res_ready_i) k++;
            res_ready_i = 0;
            cyc++;
        end
        check("drain_count", k, S);
        draining = 0;
        for (int i = 0; i < 3; i++) li[i] = 0;
        check("post_ready", ld_ready_o, 1);
        check("post_busy", busy_o, 0);
        check("post_valid", res_valid_o, 0);
        check("post_data", res_data_o, 0);
    endtask

    task automatic chk_reset();
        check("rst_ready", ld_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_start", start_o, 0);
        check("rst_valid", res_valid_o, 0);
        check("rst_data", res_data_o, 0);
        check("rst_err", err_o, 0);
    endtask

    initial begin
        logic [16:0] bseq [5];
        logic [16:0] rseq [4];
        bseq = '{17'd6, 17'd7, 17'd8, 17'd5, 17'd6};
        rseq = '{17'h1AAAA, 17'h00001, 17'h1FFFF, 17'h00002};
        ld_valid_i = 0; ld_sel_i = 0; ld_data_i = 0; go_i = 0; res_ready_i = 0;
        a_shift_i = 0; b_fetch_i = 0; p_fetch_i = 0;
        res_push_i = 0; res_i = 0; done_i = 0;
        reset_i = 1;
        mreset();
        repeat (2) @(posedge clock_i);
        #1;
        chk_reset();
        #3 reset_i = 0;

        for (int i = 0; i < S; i++) begin
            load(2'd0, 17'(i + 1));
            load(2'd1, 17'(i + 5));
            load(2'd2, 17'($urandom));
        end
        load(2'd3, 17'h1FFFF);
        check("idle_win", a_o, {17'd2, 17'd1});
        check("idle_b", b_o, 17'd5);
        step(1, 1, 1, 1, 17'h155, 1);
        step(1, 1, 1, 0, 17'h0, 0);
        check("illegal_win", a_o, {17'd2, 17'd1});
        check("illegal_b", b_o, 17'd5);

        go(0, 2'd0, 17'd0);
        step(1, 0, 0, 0, 17'd0, 0);
        check("win_shift1", a_o, {17'd4, 17'd3});
        step(1, 0, 0, 0, 17'd0, 0);
        check("win_shift2", a_o, 0);
        step(1, 0, 0, 0, 17'd0, 0);
        check("win_sat", a_o, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 17'd0, 0);
            check("b_seq", b_o, bseq[i]);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 17'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rseq[i], 0);
        step(0, 0, 0, 1, rseq[3], 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_i); #1;
            check("hold_valid", res_valid_o, 1);
            check("hold_data", res_data_o, 17'h1AAAA);
        end
        drain(0);
        check("no_err", err_o, 0);

        go(0, 2'd0, 17'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 17'($urandom), 0);
        check("ovf_err", err_o, 1);
        step(0, 0, 0, 0, 17'd0, 1);
        drain(1);
        check("ovf_sticky", err_o, 1);
        go(0, 2'd0, 17'd0);
        for (int i = 0; i < S; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1, 17'($urandom), 0);
        step(0, 0, 0, 0, 17'd0, 1);
        drain(1);

        go(0, 2'd0, 17'd0);
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1, 17'($urandom), 0);
        #3 reset_i = 1;
        #1;
        mreset();
        chk_reset();
        #10 reset_i = 0;
        for (int i = 0; i < S; i++) begin
            load(2'd0, 17'($urandom));
            load(2'd1, 17'($urandom));
            load(2'd2, 17'($urandom));
        end
        go(1, 2'd0, 17'($urandom));
        for (int i = 0; i < 30; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, 17'($urandom), 0);
        step(0, 0, 0, 1'($urandom), 17'($urandom), 1);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
